decode_intake: RTL and testbench
================================

DECODE_INTAKE -- requirements
Module: decode_intake

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronising readyIn into the clk domain (legal 2..3).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of captured-instruction entries (power of two, 2..4).
REQ-003 SHALL have port clk, input, 1, the only clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-high; clears all state immediately when high.
REQ-005 SHALL have port readyIn, input, 1, responder (issuer) ready level, asynchronous to clk.
REQ-006 SHALL have port dataIn, input, 32, instruction word, stable whenever readyIn is high.
REQ-007 SHALL have port triggerOut, output, 1, two-phase request; each toggle requests one word.
REQ-008 SHALL have port flush, input, 1, discards buffered and in-flight instructions (branch redirect).
REQ-009 SHALL have port validOut, output, 1, head FIFO entry available.
REQ-010 SHALL have port ackIn, input, 1, downstream consumes head entry when validOut=1.
REQ-011 SHALL have port instrOut, output, 32, head instruction word.
REQ-012 SHALL have port condOut, output, 4, head instrOut[31:28].
REQ-013 SHALL have port classOut, output, 3, head instruction class (REQ-022).
REQ-014 SHALL have port busyOut, output, 1, high while a handshake is outstanding.

Function
REQ-015 SHALL synchronise readyIn through SYNC_STAGES flops; rdy_s denotes the last stage; no other logic SHALL sample raw readyIn.
REQ-016 SHALL implement FSM IDLE, WAIT_LOW, WAIT_HIGH.
REQ-017 IDLE -> WAIT_LOW when rdy_s=1 and (fifo count + 0) < FIFO_DEPTH; same edge toggles triggerOut.
REQ-018 WAIT_LOW -> WAIT_HIGH when rdy_s=0; WAIT_LOW ignores rdy_s=1 (stale ready SHALL NOT complete a request).
REQ-019 WAIT_HIGH -> IDLE when rdy_s=1; same edge writes dataIn and its class into the FIFO unless the drop flag is set.
REQ-020 At most one request outstanding; triggerOut SHALL NOT toggle outside IDLE->WAIT_LOW.
REQ-021 busyOut = 1 in WAIT_LOW and WAIT_HIGH, else 0.
REQ-022 classOut encoding from the stored word w: 1 MUL if w[27:22]=0 and w[7:4]=1001; else 0 DP if w[27:26]=00; 6 UNDEF if w[27:25]=011 and w[4]=1; else 2 LDST if w[27:26]=01; 3 LDM if w[27:25]=100; 4 BRANCH if w[27:25]=101; 5 SWI if w[27:24]=1111; 7 COPROC otherwise (110, 1110). Class is computed at capture and stored.
REQ-023 Latency: validOut rises the cycle after the capture edge; instrOut/condOut/classOut are registered FIFO head, stable while validOut=1 and ackIn=0.
REQ-024 Pop on the edge with validOut=1 and ackIn=1; ackIn with validOut=0 is ignored.
REQ-025 Simultaneous capture and pop when full-minus-one or full SHALL both occur; count unchanged; no entry lost.
REQ-026 Full (count=FIFO_DEPTH): FSM stays IDLE and does not request; requesting resumes the edge after a pop.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-028 flush=1: FIFO emptied on that edge (validOut=0 next cycle); a same-edge capture is discarded; if in WAIT_LOW/WAIT_HIGH, drop flag set, handshake completes normally, word discarded, drop flag cleared at completion.
REQ-029 flush has priority over ackIn and capture on the same edge.

Reset
REQ-030 While reset=1: state IDLE, triggerOut=0, validOut=0, busyOut=0, instrOut=0, condOut=0, classOut=0, FIFO count/pointers 0, drop flag 0, synchroniser flops 0.
REQ-031 Reset mid-handshake abandons the transaction; the responder SHALL be reset by the same system reset (phase realigned at triggerOut=0).
REQ-032 First request no earlier than SYNC_STAGES+1 cycles after reset release (rdy_s must observe readyIn=1).

Verification
REQ-033 Reset release, responder returns 0xE3A01005 -> one triggerOut toggle, busyOut high, validOut=1, instrOut=0xE3A01005, condOut=0xE, classOut=0.
REQ-034 ackIn held 0, responder supplies 0xEA000004, 0xE5912000, 0xE0010392 -> first two buffered (classOut 4 then 2), no third toggle until one ackIn; third gives classOut=1.
REQ-035 readyIn held high with no low phase after toggle -> FSM stays WAIT_LOW, no capture, validOut stays 0.
REQ-036 flush pulsed during WAIT_HIGH with one entry buffered -> validOut=0 next cycle, in-flight word discarded, next request captured normally.
REQ-037 Full FIFO, ackIn=1 on the same edge as capture -> count stays 2, order preserved; 0xEF000000 -> classOut=5, 0xE7F000F0 -> classOut=6.
REQ-038 reset asserted in WAIT_HIGH -> triggerOut=0, validOut=0, busyOut=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/decode_intake.sv
// decode_intake: fetches instruction words from an asynchronous responder
// using a two-phase request / level-ready handshake, classifies each word at
// capture time and buffers it in a small FIFO for the decode stage.
//
// Handshakes:
//   Responder side: each toggle of triggerOut requests one word. The responder
//   answers by dropping readyIn, then presenting dataIn and raising readyIn
//   again. dataIn must be stable while readyIn is high. Only the synchronised
//   copy rdy_s is ever looked at, and a request completes only after rdy_s has
//   been seen low and then high again.
//   Downstream side: validOut means the head entry (instrOut/condOut/classOut)
//   is available. The head is consumed on a rising clk edge where validOut=1
//   and ackIn=1. ackIn while validOut=0 has no effect. flush wins over ackIn
//   and over a capture on the same edge.
module decode_intake #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readyIn,
    input  logic [31:0] dataIn,
    output logic        triggerOut,
    input  logic        flush,
    output logic        validOut,
    input  logic        ackIn,
    output logic [31:0] instrOut,
    output logic [3:0]  condOut,
    output logic [2:0]  classOut,
    output logic        busyOut,
    output logic [1:0]  state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Handshake states; the encoding is visible on state_dbg.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] rdy_sync;
    logic                   rdy_s;

    logic             req_fire;
    logic             done;
    logic             drop;
    logic             push;
    logic             pop;
    logic             full;

    logic [31:0]      mem_word  [FIFO_DEPTH];
    logic [2:0]       mem_class [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Instruction class of a word, decided at capture and stored with it.
    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [2:0] c;
        if (w[27:22] == 6'b000000 && w[7:4] == 4'b1001) begin
            c = 3'd1;
        end else if (w[27:26] == 2'b00) begin
            c = 3'd0;
        end else if (w[27:25] == 3'b011 && w[4]) begin
            c = 3'd6;
        end else if (w[27:26] == 2'b01) begin
            c = 3'd2;
        end else if (w[27:25] == 3'b100) begin
            c = 3'd3;
        end else if (w[27:25] == 3'b101) begin
            c = 3'd4;
        end else if (w[27:24] == 4'b1111) begin
            c = 3'd5;
        end else begin
            c = 3'd7;
        end
        return c;
    endfunction

    assign rdy_s = rdy_sync[SYNC_STAGES-1];

    // Bring the asynchronous ready level into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_sync <= '0;
        end else if (SYNC_STAGES > 1) begin
            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], readyIn};
        end else begin
            rdy_sync <= readyIn;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: request only with room in the FIFO, and require a fresh
    // low-then-high ready so a stale ready never completes a request.
    always_comb begin
        state_next = state;
        req_fire   = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rdy_s && !full) begin
                    state_next = WAIT_LOW;
                    req_fire   = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!rdy_s) begin
                    state_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rdy_s) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Two-phase request line: one toggle per requested word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            triggerOut <= 1'b0;
        end else if (req_fire) begin
            triggerOut <= ~triggerOut;
        end
    end

    // Drop flag: a flush during a handshake lets it finish but discards the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (done) begin
            drop <= 1'b0;
        end else if (flush && state != IDLE) begin
            drop <= 1'b1;
        end
    end

    assign full = (count == DEPTH_C);
    assign push = done && !drop && !flush && (!full || pop);
    assign pop  = validOut && ackIn && !flush;

    // FIFO storage, pointers and occupancy; flush empties it outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_word[i]  <= '0;
                mem_class[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_word[wr_ptr]  <= dataIn;
                mem_class[wr_ptr] <= classify(dataIn);
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign validOut  = (count != '0);
    assign instrOut  = validOut ? mem_word[rd_ptr] : 32'd0;
    assign classOut  = validOut ? mem_class[rd_ptr] : 3'd0;
    assign condOut   = instrOut[31:28];
    assign busyOut   = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_decode_intake.sv
// Bench for decode_intake: a responder model answers each request, an
// expected queue holds the words that must come out in order, and a negedge
// monitor compares the FIFO head against it and drives ackIn.
module tb_decode_intake;

    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 2;

    logic        clk;
    logic        reset;
    logic        readyIn;
    logic [31:0] dataIn;
    logic        triggerOut;
    logic        flush;
    logic        validOut;
    logic        ackIn;
    logic [31:0] instrOut;
    logic [3:0]  condOut;
    logic [2:0]  classOut;
    logic        busyOut;
    logic [1:0]  state_dbg;

    int          checks;
    int          failures;
    int          ack_mode;
    logic        last_trig;
    logic [31:0] mon_w;
    logic [31:0] exp_q[$];

    decode_intake #(
        .SYNC_STAGES(SYNC_STAGES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .readyIn   (readyIn),
        .dataIn    (dataIn),
        .triggerOut(triggerOut),
        .flush     (flush),
        .validOut  (validOut),
        .ackIn     (ackIn),
        .instrOut  (instrOut),
        .condOut   (condOut),
        .classOut  (classOut),
        .busyOut   (busyOut),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Class from the opcode field groups of the word.
    function automatic logic [2:0] ref_class(input logic [31:0] w);
        if (w[27:22] == 6'd0 && w[7:4] == 4'b1001) return 3'd1;
        case (w[27:26])
            2'b00:   return 3'd0;
            2'b01:   return (w[25] && w[4]) ? 3'd6 : 3'd2;
            2'b10:   return w[25] ? 3'd4 : 3'd3;
            default: return (w[25:24] == 2'b11) ? 3'd5 : 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            w[27:22] = 6'd0;
            w[7:4]   = 4'b1001;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            ackIn = 1'b0;
        end else begin
            case (ack_mode)
                0:       ackIn = 1'b0;
                1:       ackIn = 1'b1;
                default: ackIn = 1'($urandom_range(0, 1));
            endcase
            if (!flush && validOut) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_expect", {31'd0, validOut}, 32'd0);
                end else begin
                    mon_w = exp_q[0];
                    check("instr", instrOut, mon_w);
                    check("cond", {28'd0, condOut}, {28'd0, mon_w[31:28]});
                    check("class", {29'd0, classOut}, {29'd0, ref_class(mon_w)});
                    if (ackIn) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks (responder model) ----------------
    task automatic wait_toggle();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (triggerOut !== last_trig) begin
                last_trig = triggerOut;
                return;
            end
        end
        check("req_timeout", {31'd0, triggerOut}, {31'd0, ~last_trig});
    endtask

    task automatic finish_one(input logic [31:0] w, input bit do_flush, input int low);
        check("busy_in_handshake", {31'd0, busyOut}, 32'd1);
        readyIn = 1'b0;
        for (int i = 0; i < low; i++) begin
            @(posedge clk);
            #2;
            check("no_extra_toggle", {31'd0, triggerOut}, {31'd0, last_trig});
        end
        if (do_flush) begin
            if (low >= SYNC_STAGES + 2) check("wait_high_before_flush", {30'd0, state_dbg}, 32'd2);
            flush = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            check("flush_clears_valid", {31'd0, validOut}, 32'd0);
            check("busy_after_flush", {31'd0, busyOut}, 32'd1);
            #1;
            flush = 1'b0;
        end
        dataIn  = w;
        readyIn = 1'b1;
        if (!do_flush) exp_q.push_back(w);
    endtask

    task automatic serve(input logic [31:0] w, input bit do_flush, input int low);
        wait_toggle();
        finish_one(w, do_flush, low);
    endtask

    task automatic drain();
        ack_mode = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0 && !validOut) break;
        end
        check("drain_valid", {31'd0, validOut}, 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        ack_mode = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        failures  = 0;
        ack_mode  = 0;
        last_trig = 1'b0;
        reset     = 1'b1;
        readyIn   = 1'b1;
        dataIn    = 32'd0;
        flush     = 1'b0;
        ackIn     = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_trigger", {31'd0, triggerOut}, 32'd0);
        check("rst_valid", {31'd0, validOut}, 32'd0);
        check("rst_busy", {31'd0, busyOut}, 32'd0);
        check("rst_instr", instrOut, 32'd0);
        check("rst_cond", {28'd0, condOut}, 32'd0);
        check("rst_class", {29'd0, classOut}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);

        // First request only once the synchroniser has seen ready.
        @(negedge clk);
        reset = 1'b0;
        repeat (SYNC_STAGES) @(posedge clk);
        #2;
        check("no_early_req", {31'd0, triggerOut}, 32'd0);
        @(posedge clk);
        #2;
        check("first_req", {31'd0, triggerOut}, 32'd1);
        check("first_busy", {31'd0, busyOut}, 32'd1);
        serve(32'hE3A01005, 1'b0, 2);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (validOut) break;
        end
        check("first_valid", {31'd0, validOut}, 32'd1);
        drain();

        // Fill the FIFO with ackIn held low; no request while full.
        serve(32'hEA000004, 1'b0, 2);
        serve(32'hE5912000, 1'b0, 3);
        repeat (30) @(posedge clk);
        #2;
        check("full_no_req", {31'd0, triggerOut}, {31'd0, last_trig});
        check("full_idle", {30'd0, state_dbg}, 32'd0);
        check("full_not_busy", {31'd0, busyOut}, 32'd0);
        check("full_valid", {31'd0, validOut}, 32'd1);
        ack_mode = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 1) break;
        end
        ack_mode = 0;
        serve(32'hE0010392, 1'b0, 2);
        drain();

        // Ready held high after the toggle must not complete the request.
        wait_toggle();
        repeat (20) @(posedge clk);
        #2;
        check("stale_wait_low", {30'd0, state_dbg}, 32'd1);
        check("stale_no_valid", {31'd0, validOut}, 32'd0);
        check("stale_busy", {31'd0, busyOut}, 32'd1);
        finish_one(32'hE1A00000, 1'b0, 3);
        drain();

        // Flush during WAIT_HIGH with one entry buffered.
        serve(32'hE2811001, 1'b0, 2);
        serve(32'hE3500000, 1'b1, 6);
        serve(32'hE0800001, 1'b0, 2);
        drain();

        // Full FIFO, then continuous ack so captures overlap pops.
        serve(32'hEF000000, 1'b0, 2);
        serve(32'hE7F000F0, 1'b0, 2);
        ack_mode = 1;
        serve(32'hE3A0200A, 1'b0, 1);
        serve(32'hE8BD8000, 1'b0, 4);
        drain();

        // Randomised traffic with random ack, low times and flushes.
        ack_mode = 2;
        for (int n = 0; n < 60; n++) begin
            wait_toggle();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
            end
            finish_one(rand_word(), ($urandom_range(0, 7) == 0), int'($urandom_range(1, 6)));
        end
        drain();

        // Reset in WAIT_HIGH clears outputs without a clock edge.
        serve(32'hE3A01005, 1'b0, 2);
        wait_toggle();
        readyIn = 1'b0;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #2;
        check("pre_reset_wait_high", {30'd0, state_dbg}, 32'd2);
        check("pre_reset_valid", {31'd0, validOut}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_trigger", {31'd0, triggerOut}, 32'd0);
        check("async_rst_valid", {31'd0, validOut}, 32'd0);
        check("async_rst_busy", {31'd0, busyOut}, 32'd0);
        check("async_rst_instr", instrOut, 32'd0);
        check("async_rst_state", {30'd0, state_dbg}, 32'd0);
        last_trig = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
